// File: rtl/pipeline_stall_ctrl.sv
// Central stall/flush controller for the 5-stage core: merges stage stall requests,
// orders flushes behind outstanding MEM/WB accesses, and tracks stall watchdog/perf stats.
module pipeline_stall_ctrl #(
  parameter int STALL_TIMEOUT = 1024,
  parameter int CNT_WIDTH     = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [4:0]           stall_req,
  input  logic                 flush_req,
  input  logic [31:0]          flush_pc_in,
  input  logic                 timeout_clr,
  output logic [4:0]           stall,
  output logic                 flush,
  output logic [31:0]          flush_pc,
  output logic                 flush_pending,
  output logic                 stall_timeout,
  output logic [CNT_WIDTH-1:0] stall_cycles
);

  localparam int WD_W = $clog2(STALL_TIMEOUT) + 1;
  localparam logic [WD_W-1:0] TO_VAL = WD_W'(STALL_TIMEOUT);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PEND  = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t          state;
  logic [31:0]     pend_pc;
  logic [WD_W-1:0] wd_cnt;
  logic            stall_any;
  logic            hold;

  // A stalled stage freezes itself and every stage upstream of it.
  assign stall[4]  = stall_req[4];
  assign stall[3]  = |stall_req[4:3];
  assign stall[2]  = |stall_req[4:2];
  assign stall[1]  = |stall_req[4:1];
  assign stall[0]  = |stall_req[4:0];

  assign stall_any = |stall_req;
  assign hold      = stall_req[3] | stall_req[4];

  // Flush sequencing; flush_pc only changes when a flush is actually issued.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      pend_pc       <= '0;
      flush         <= 1'b0;
      flush_pc      <= '0;
      flush_pending <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          flush <= 1'b0;
          if (flush_req) begin
            pend_pc <= flush_pc_in;
            if (hold) begin
              state         <= PEND;
              flush_pending <= 1'b1;
            end else begin
              state    <= FLUSH;
              flush    <= 1'b1;
              flush_pc <= flush_pc_in;
            end
          end
        end
        PEND: begin
          if (!hold) begin
            state         <= FLUSH;
            flush         <= 1'b1;
            flush_pc      <= pend_pc;
            flush_pending <= 1'b0;
          end
        end
        FLUSH: begin
          state <= IDLE;
          flush <= 1'b0;
        end
        default: begin
          state         <= IDLE;
          flush         <= 1'b0;
          flush_pending <= 1'b0;
        end
      endcase
    end
  end

  // Watchdog run counter saturates at the timeout; a clear overrides a same-cycle set.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wd_cnt        <= '0;
      stall_timeout <= 1'b0;
    end else if (timeout_clr) begin
      wd_cnt        <= '0;
      stall_timeout <= 1'b0;
    end else if (!stall_any) begin
      wd_cnt <= '0;
    end else if (wd_cnt != TO_VAL) begin
      wd_cnt <= wd_cnt + 1'b1;
      if (wd_cnt == TO_VAL - 1'b1)
        stall_timeout <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      stall_cycles <= '0;
    else if (stall_any)
      stall_cycles <= stall_cycles + 1'b1;
  end

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Scoreboard bench for pipeline_stall_ctrl: stimulus queues cycle-tagged expectations,
// a negedge monitor compares them and checks every flush pulse against expected PCs.
module tb_pipeline_stall_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  stall_req;
  logic        flush_req;
  logic [31:0] flush_pc_in;
  logic        timeout_clr;
  logic [4:0]  stall;
  logic        flush;
  logic [31:0] flush_pc;
  logic        flush_pending;
  logic        stall_timeout;
  logic [3:0]  stall_cycles;

  pipeline_stall_ctrl #(.STALL_TIMEOUT(8), .CNT_WIDTH(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .stall_req     (stall_req),
    .flush_req     (flush_req),
    .flush_pc_in   (flush_pc_in),
    .timeout_clr   (timeout_clr),
    .stall         (stall),
    .flush         (flush),
    .flush_pc      (flush_pc),
    .flush_pending (flush_pending),
    .stall_timeout (stall_timeout),
    .stall_cycles  (stall_cycles)
  );

  always #5 clk = ~clk;

  typedef enum {F_STALL, F_FLUSH, F_PC, F_PEND, F_TMO, F_CNT} field_e;
  typedef struct {
    int          cyc;
    field_e      fld;
    logic [31:0] val;
  } exp_t;

  exp_t        expQ[$];
  logic [31:0] flushQ[$];
  int          cyc = 0;
  int          compared = 0;
  int          mismatched = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] getField(field_e f);
    case (f)
      F_STALL: return {27'd0, stall};
      F_FLUSH: return {31'd0, flush};
      F_PC:    return flush_pc;
      F_PEND:  return {31'd0, flush_pending};
      F_TMO:   return {31'd0, stall_timeout};
      default: return {28'd0, stall_cycles};
    endcase
  endfunction

  // Monitor: compare due expectations and pop an expected PC for every flush pulse.
  always @(negedge clk) begin
    logic [31:0] act;
    logic [31:0] pc;
    for (int i = expQ.size() - 1; i >= 0; i--) begin
      if (expQ[i].cyc == cyc) begin
        act = getField(expQ[i].fld);
        compared++;
        if (act !== expQ[i].val) begin
          mismatched++;
          $display("[TB] FAIL %s cyc=%0d actual=0x%0h expected=0x%0h",
                   expQ[i].fld.name(), cyc, act, expQ[i].val);
        end
        expQ.delete(i);
      end
    end
    if (flush !== 1'b0) begin
      compared++;
      if (flushQ.size() == 0) begin
        mismatched++;
        $display("[TB] FAIL unexpected_flush cyc=%0d actual flush=%b pc=0x%0h expected flush=0",
                 cyc, flush, flush_pc);
      end else begin
        pc = flushQ.pop_front();
        if (flush_pc !== pc) begin
          mismatched++;
          $display("[TB] FAIL flush_pc_pulse cyc=%0d actual=0x%0h expected=0x%0h",
                   cyc, flush_pc, pc);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [4:0] sreq, input logic freq,
                               input logic [31:0] pc, input logic clr);
    stall_req   = sreq;
    flush_req   = freq;
    flush_pc_in = pc;
    timeout_clr = clr;
  endtask

  task automatic checkOutput(input field_e f, input logic [31:0] v, input int dly);
    exp_t e;
    e.cyc = cyc + dly;
    e.fld = f;
    e.val = v;
    expQ.push_back(e);
  endtask

  task automatic expectFlush(input logic [31:0] pc);
    flushQ.push_back(pc);
  endtask

  initial begin
    rst = 1'b0;
    applyStimulus(5'b00100, 1'b0, 32'h0, 1'b0);
    tick();
    // Reset state; stall vector stays live during reset.
    checkOutput(F_STALL, 32'b00111, 0);
    checkOutput(F_FLUSH, 0, 0);
    checkOutput(F_PC, 0, 0);
    checkOutput(F_PEND, 0, 0);
    checkOutput(F_TMO, 0, 0);
    checkOutput(F_CNT, 0, 0);
    tick();
    rst = 1'b1;
    applyStimulus(5'b00000, 1'b0, 32'h0, 1'b0);
    checkOutput(F_STALL, 0, 0);
    checkOutput(F_CNT, 0, 0);
    tick();

    // Stall vector propagation
    applyStimulus(5'b01000, 1'b0, 32'h0, 1'b0);
    checkOutput(F_STALL, 32'b01111, 0);
    tick();
    applyStimulus(5'b00000, 1'b0, 32'h0, 1'b0);
    checkOutput(F_STALL, 0, 0);
    checkOutput(F_CNT, 1, 0);
    tick();

    // Immediate flush
    applyStimulus(5'b00000, 1'b1, 32'hBFC00380, 1'b0);
    checkOutput(F_FLUSH, 0, 0);
    checkOutput(F_FLUSH, 1, 1);
    checkOutput(F_PC, 32'hBFC00380, 1);
    expectFlush(32'hBFC00380);
    tick();
    applyStimulus(5'b00000, 1'b0, 32'h0, 1'b0);
    checkOutput(F_PEND, 0, 0);
    checkOutput(F_FLUSH, 0, 1);
    tick();
    tick();

    // Flush deferred behind MEM stall; first PC wins
    applyStimulus(5'b01000, 1'b1, 32'h80000180, 1'b0);
    checkOutput(F_PEND, 0, 0);
    tick();
    applyStimulus(5'b01000, 1'b1, 32'h00001234, 1'b0);
    checkOutput(F_PEND, 1, 0);
    tick();
    applyStimulus(5'b01000, 1'b0, 32'h0, 1'b0);
    checkOutput(F_PEND, 1, 0);
    tick();
    applyStimulus(5'b01000, 1'b0, 32'h0, 1'b0);
    checkOutput(F_PEND, 1, 0);
    checkOutput(F_FLUSH, 0, 0);
    tick();
    applyStimulus(5'b00000, 1'b0, 32'h0, 1'b0);
    checkOutput(F_PEND, 1, 0);
    checkOutput(F_FLUSH, 0, 0);
    checkOutput(F_CNT, 5, 0);
    checkOutput(F_FLUSH, 1, 1);
    checkOutput(F_PC, 32'h80000180, 1);
    checkOutput(F_PEND, 0, 1);
    expectFlush(32'h80000180);
    tick();
    // Stall alongside flush; flush_req during FLUSH is ignored
    applyStimulus(5'b00001, 1'b1, 32'hDEADBEEF, 1'b0);
    checkOutput(F_STALL, 32'b00001, 0);
    tick();
    applyStimulus(5'b00000, 1'b0, 32'h0, 1'b0);
    checkOutput(F_FLUSH, 0, 0);
    checkOutput(F_PC, 32'h80000180, 0);
    checkOutput(F_CNT, 6, 0);
    tick();

    // Watchdog sets after 8 stalled edges, then clears
    for (int i = 0; i < 8; i++) begin
      applyStimulus(5'b00100, 1'b0, 32'h0, 1'b0);
      checkOutput(F_TMO, 0, 0);
      tick();
    end
    applyStimulus(5'b00000, 1'b0, 32'h0, 1'b0);
    checkOutput(F_TMO, 1, 0);
    checkOutput(F_CNT, 14, 0);
    tick();
    applyStimulus(5'b00000, 1'b0, 32'h0, 1'b1);
    checkOutput(F_TMO, 1, 0);
    tick();
    applyStimulus(5'b00000, 1'b0, 32'h0, 1'b0);
    checkOutput(F_TMO, 0, 0);
    tick();

    // Clear coinciding with the set edge wins
    for (int i = 0; i < 8; i++) begin
      applyStimulus(5'b00100, 1'b0, 32'h0, (i == 7));
      tick();
    end
    applyStimulus(5'b00000, 1'b0, 32'h0, 1'b0);
    checkOutput(F_TMO, 0, 0);
    checkOutput(F_CNT, 6, 0);
    tick();

    // Reset while a flush is pending drops it
    applyStimulus(5'b10000, 1'b1, 32'hCAFE0000, 1'b0);
    tick();
    applyStimulus(5'b10000, 1'b0, 32'h0, 1'b0);
    checkOutput(F_PEND, 1, 0);
    checkOutput(F_CNT, 7, 0);
    tick();
    rst = 1'b0;
    checkOutput(F_PEND, 0, 0);
    checkOutput(F_CNT, 0, 0);
    checkOutput(F_STALL, 32'b11111, 0);
    checkOutput(F_FLUSH, 0, 0);
    tick();
    rst = 1'b1;
    applyStimulus(5'b00000, 1'b0, 32'h0, 1'b0);
    checkOutput(F_PEND, 0, 0);
    checkOutput(F_FLUSH, 0, 0);
    checkOutput(F_PC, 0, 0);
    tick();
    checkOutput(F_FLUSH, 0, 0);
    tick();
    tick();

    // Performance counter wraps at 4 bits
    for (int i = 0; i < 17; i++) begin
      applyStimulus(5'b00010, 1'b0, 32'h0, 1'b0);
      if (i == 0 || i == 15) checkOutput(F_CNT, i, 0);
      if (i == 16) checkOutput(F_CNT, 0, 0);
      tick();
    end
    applyStimulus(5'b00000, 1'b0, 32'h0, 1'b0);
    checkOutput(F_CNT, 1, 0);
    tick();
    tick();
    tick();

    compared++;
    if (expQ.size() != 0) begin
      mismatched++;
      $display("[TB] FAIL expect_queue_drain actual=%0d entries expected=0", expQ.size());
    end
    compared++;
    if (flushQ.size() != 0) begin
      mismatched++;
      $display("[TB] FAIL flush_queue_drain actual=%0d entries expected=0", flushQ.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
